// File: rtl/ecc_secded_mem.sv
// SECDED-protected memory: extended-Hamming encode on write, two-stage decode/correct on read,
// with read-path error injection counters for forcing correctable/uncorrectable responses.
module ecc_secded_mem #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 512,
  parameter int CNT_WIDTH  = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  output logic                  rd_uncorrectable,
  input  logic                  inj_corr_load,
  input  logic                  inj_uncorr_load,
  input  logic [CNT_WIDTH-1:0]  inj_count,
  output logic [CNT_WIDTH-1:0]  inj_corr_remaining,
  output logic [CNT_WIDTH-1:0]  inj_uncorr_remaining
);
  localparam int R  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1);
  localparam int CW = R + 1;
  localparam int N  = DATA_WIDTH + CW;
  localparam int NW = $clog2(N);

  // Codeword bit 0 is overall parity; bits 1..N-1 are Hamming positions (powers of two = check bits).
  function automatic logic [N-1:0] encode(input logic [DATA_WIDTH-1:0] d);
    logic [N-1:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    for (int i = 0; i < R; i++)
      for (int p = 1; p < N; p++)
        if (((p >> i) & 1) != 0 && p != (1 << i)) c[1 << i] = c[1 << i] ^ c[p];
    c[0] = ^c[N-1:1];
    return c;
  endfunction

  logic [N-1:0]         mem [DEPTH];
  logic [N-1:0]         s1_cw;
  logic [1:0]           vld_pipe;
  logic [CNT_WIDTH-1:0] correctable_errors_to_inject_ff;
  logic [CNT_WIDTH-1:0] uncorrectable_errors_to_inject_ff;
  logic                 inj_unc, inj_cor;
  logic [NW-1:0]        flip_idx;
  logic [N-1:0]         flip;

  always_comb begin
    inj_unc  = uncorrectable_errors_to_inject_ff != '0;
    inj_cor  = !inj_unc && (correctable_errors_to_inject_ff != '0);
    flip_idx = NW'(32'(rd_addr) % 32'(N));
    flip     = '0;
    if (inj_unc)      flip[1:0]      = 2'b11;
    else if (inj_cor) flip[flip_idx] = 1'b1;
  end

  // Array and stage-1 word are not reset; nonblocking write gives read-first on collisions.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= encode(wr_data);
    if (rd_en) s1_cw <= mem[rd_addr] ^ flip;
  end

  // A load overrides a same-cycle decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      correctable_errors_to_inject_ff   <= '0;
      uncorrectable_errors_to_inject_ff <= '0;
    end else begin
      if (inj_uncorr_load)
        uncorrectable_errors_to_inject_ff <= inj_count;
      else if (rd_en && inj_unc)
        uncorrectable_errors_to_inject_ff <= uncorrectable_errors_to_inject_ff - CNT_WIDTH'(1);
      if (inj_corr_load)
        correctable_errors_to_inject_ff <= inj_count;
      else if (rd_en && inj_cor)
        correctable_errors_to_inject_ff <= correctable_errors_to_inject_ff - CNT_WIDTH'(1);
    end
  end

  assign inj_corr_remaining   = correctable_errors_to_inject_ff;
  assign inj_uncorr_remaining = uncorrectable_errors_to_inject_ff;

  logic [R-1:0]          syn;
  logic                  par;
  logic [N-1:0]          fixed;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_err, dec_unc;

  always_comb begin
    int k;
    k   = 0;
    syn = '0;
    for (int p = 1; p < N; p++)
      if (s1_cw[p]) syn = syn ^ R'(p);
    par      = ^s1_cw;
    fixed    = s1_cw;
    dec_err  = 1'b0;
    dec_unc  = 1'b0;
    dec_data = '0;
    if (par) begin
      dec_err = 1'b1;
      if (32'(syn) < 32'(N)) fixed[syn] = ~fixed[syn];
      else                   dec_unc    = 1'b1;
    end else if (syn != '0) begin
      dec_err = 1'b1;
      dec_unc = 1'b1;
    end
    for (int p = 1; p < N; p++)
      if ((p & (p - 1)) != 0) begin
        dec_data[k] = fixed[p];
        k++;
      end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe         <= '0;
      rd_data          <= '0;
      rd_err           <= 1'b0;
      rd_uncorrectable <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_en};
      if (vld_pipe[0]) begin
        rd_data          <= dec_data;
        rd_err           <= dec_err;
        rd_uncorrectable <= dec_unc;
      end
    end
  end

  assign rd_valid = vld_pipe[1];
endmodule

// File: tb/tb_ecc_secded_mem.sv
// Scoreboard bench for ecc_secded_mem: expected responses queued at request time, popped on rd_valid.
module tb_ecc_secded_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, inj_corr_load, inj_uncorr_load;
  logic [8:0]  wr_addr, rd_addr;
  logic [63:0] wr_data, rd_data;
  logic        rd_valid, rd_err, rd_uncorrectable;
  logic [31:0] inj_count, inj_corr_remaining, inj_uncorr_remaining;

  ecc_secded_mem dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_uncorrectable(rd_uncorrectable),
    .inj_corr_load(inj_corr_load), .inj_uncorr_load(inj_uncorr_load), .inj_count(inj_count),
    .inj_corr_remaining(inj_corr_remaining), .inj_uncorr_remaining(inj_uncorr_remaining)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic err; logic unc; } exp_t;
  exp_t        sb[$];
  logic [63:0] mem_m [512];
  int          mc = 0, mu = 0;
  int          checks = 0, errors = 0;
  int          n_err = 0, n_unc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 64'(rd_valid), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", rd_data, e.data);
        chk("rd_err", 64'(rd_err), 64'(e.err));
        chk("rd_unc", 64'(rd_uncorrectable), 64'(e.unc));
        if (rd_err) n_err++;
        if (rd_uncorrectable) n_unc++;
      end
    end
  end

  // One clock of stimulus; the model reads before it writes (read-first) and injects before loads.
  task automatic cyc(input logic we, input int wa, input logic [63:0] wd,
                     input logic re, input int ra,
                     input logic lc, input logic lu, input int cnt);
    exp_t e;
    wr_en = we; wr_addr = wa[8:0]; wr_data = wd;
    rd_en = re; rd_addr = ra[8:0];
    inj_corr_load = lc; inj_uncorr_load = lu; inj_count = cnt;
    if (re) begin
      e.data = mem_m[ra]; e.err = 1'b0; e.unc = 1'b0;
      if (mu != 0) begin e.err = 1'b1; e.unc = 1'b1; mu--; end
      else if (mc != 0) begin e.err = 1'b1; mc--; end
      sb.push_back(e);
    end
    if (lc) mc = cnt;
    if (lu) mu = cnt;
    if (we) mem_m[wa] = wd;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; inj_corr_load = 1'b0; inj_uncorr_load = 1'b0;
  endtask

  task automatic rd(input int a);
    cyc(1'b0, 0, 64'd0, 1'b1, a, 1'b0, 1'b0, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk); #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; inj_corr_load = 1'b0; inj_uncorr_load = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; inj_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_err", 64'({rd_err, rd_uncorrectable}), 64'd0);
    chk("rst_corr_cnt", 64'(inj_corr_remaining), 64'd0);
    chk("rst_unc_cnt", 64'(inj_uncorr_remaining), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: fill and clean readback
    for (int i = 0; i < 512; i++) cyc(1'b1, i, 64'(i) * 64'h0101_0101_0101_0101, 1'b0, 0, 1'b0, 1'b0, 0);
    n_err = 0; n_unc = 0;
    for (int i = 0; i < 512; i++) rd(i);
    drain("t1_drain");
    chk("t1_nerr", 64'(n_err), 64'd0);

    // 2: 100 correctable
    cyc(1'b0, 0, 64'd0, 1'b0, 0, 1'b1, 1'b0, 100);
    n_err = 0; n_unc = 0;
    for (int i = 0; i < 512; i++) rd(i);
    drain("t2_drain");
    chk("t2_nerr", 64'(n_err), 64'd100);
    chk("t2_nunc", 64'(n_unc), 64'd0);
    chk("t2_rem", 64'(inj_corr_remaining), 64'(mc));

    // 3: 100 uncorrectable
    cyc(1'b0, 0, 64'd0, 1'b0, 0, 1'b0, 1'b1, 100);
    n_err = 0; n_unc = 0;
    for (int i = 0; i < 512; i++) rd(i);
    drain("t3_drain");
    chk("t3_nerr", 64'(n_err), 64'd100);
    chk("t3_nunc", 64'(n_unc), 64'd100);
    chk("t3_rem", 64'(inj_uncorr_remaining), 64'(mu));

    // 4: priority U,U,C,C,C,clean
    cyc(1'b0, 0, 64'd0, 1'b0, 0, 1'b1, 1'b1, 3);
    cyc(1'b0, 0, 64'd0, 1'b0, 0, 1'b0, 1'b1, 2);
    for (int i = 0; i < 6; i++) rd(40 + i);
    drain("t4_drain");
    // load alongside a read: that read is clean, load value survives
    cyc(1'b0, 0, 64'd0, 1'b1, 20, 1'b1, 1'b0, 2);
    for (int i = 0; i < 3; i++) rd(71 + i);
    drain("t4b_drain");
    chk("t4b_rem", 64'(inj_corr_remaining), 64'(mc));

    // 5: read-first collision
    cyc(1'b1, 5, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 5, 64'h5555_5555_5555_5555, 1'b1, 5, 1'b0, 1'b0, 0);
    rd(5);
    drain("t5_drain");

    // 6: reset with reads in flight
    cyc(1'b0, 0, 64'd0, 1'b0, 0, 1'b1, 1'b1, 7);
    rd_en = 1'b1; rd_addr = 9'd10;
    @(posedge clk); #1;
    rd_addr = 9'd11;
    #2 rst = 1'b0;
    rd_en = 1'b0;
    mc = 0; mu = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_valid_in_rst", 64'(rd_valid), 64'd0);
    end
    chk("t6_corr_cnt", 64'(inj_corr_remaining), 64'd0);
    chk("t6_unc_cnt", 64'(inj_uncorr_remaining), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rd(10); rd(11); rd(5); rd(300);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
